fir_circmem_mc: RTL and testbench

Multi-channel, parametrised circular sample memory for the FPU FIR datapath. It runs on a single clock, replacing the earlier sample-clock/64x-clock split. Each accepted input frame (one sample per channel) is written into per-channel ring buffers. The block then streams every channel's tap history, newest to oldest, to the downstream MAC. An optional symmetric-fold mode pre-adds mirrored taps, halving MAC work for linear-phase filters.

---
 rtl/fir_circmem_mc.sv | 174 +++++++++++++++++
 tb/tb_fir_circmem_mc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_circmem_mc.sv
// fir_circmem_mc: multi-channel circular sample memory streaming tap histories to a MAC.
// Optional symmetric fold of mirrored taps is enabled by defining FIR_CIRCMEM_SYMFOLD_EN.
`default_nettype none

module fir_circmem_mc #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 6,
  parameter int CWIDTH = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din_vld,
  input  logic [(1<<CWIDTH)*DWIDTH-1:0] din,
  output logic                          din_rdy,
  output logic [DWIDTH:0]               dout,
  output logic                          dout_vld,
  output logic [CWIDTH-1:0]             dout_ch,
  output logic [AWIDTH-1:0]             dout_tap,
  output logic                          dout_last,
  output logic                          ovr
);

  localparam int NCH   = 1 << CWIDTH;
  localparam int T     = 1 << AWIDTH;
  localparam int DEPTH = NCH * T;
`ifdef FIR_CIRCMEM_SYMFOLD_EN
  localparam int KW = AWIDTH - 1;
`else
  localparam int KW = AWIDTH;
`endif
  localparam int NISSUE = NCH << KW;
  localparam int CNTW   = CWIDTH + AWIDTH + 1;
  localparam int MAW    = CWIDTH + AWIDTH;

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE, READ} state_t;

  state_t                    state, state_nxt;
  logic [CNTW-1:0]           cnt, cnt_nxt;
  logic [AWIDTH-1:0]         wptr;
  logic [NCH*DWIDTH-1:0]     frame;
  logic [DWIDTH-1:0]         mem [DEPTH];

  logic                      we;
  logic [MAW-1:0]            waddr;
  logic [DWIDTH-1:0]         wdata;
  logic                      issue, last_issue;
  logic [AWIDTH-1:0]         k_full;
  logic [CWIDTH-1:0]         rch;
  logic [MAW-1:0]            raddr_a;
  logic [DWIDTH-1:0]         rd_a;
  logic                      v1, last1;
  logic [CWIDTH-1:0]         ch1;
  logic [AWIDTH-1:0]         tap1;
  logic [DWIDTH:0]           sum;

  assign din_rdy = (state == IDLE);

  // READ keeps two extra cycles after the last issue so the pipeline drains
  // before din_rdy returns.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNTW'(1);
    case (state)
      CLEAR: if (cnt == CNTW'(DEPTH - 1)) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      IDLE: begin
        cnt_nxt = '0;
        if (din_vld) state_nxt = WRITE;
      end
      WRITE: if (cnt == CNTW'(NCH - 1)) begin
        state_nxt = READ;
        cnt_nxt   = '0;
      end
      READ: if (cnt == CNTW'(NISSUE + 1)) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    we    = 1'b0;
    waddr = cnt[MAW-1:0];
    wdata = '0;
    if (state == CLEAR) begin
      we = 1'b1;
    end else if (state == WRITE) begin
      we    = 1'b1;
      waddr = {cnt[CWIDTH-1:0], wptr};
      wdata = frame[int'(cnt[CWIDTH-1:0])*DWIDTH +: DWIDTH];
    end
  end

  assign issue      = (state == READ) && (cnt < CNTW'(NISSUE));
  assign last_issue = (cnt == CNTW'(NISSUE - 1));
  assign rch        = cnt[KW +: CWIDTH];
`ifdef FIR_CIRCMEM_SYMFOLD_EN
  assign k_full     = {1'b0, cnt[KW-1:0]};
`else
  assign k_full     = cnt[AWIDTH-1:0];
`endif
  assign raddr_a    = {rch, wptr - k_full};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      wptr  <= '0;
      frame <= '0;
      ovr   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && din_vld) frame <= din;
      if (state == READ && state_nxt == IDLE) wptr <= wptr + AWIDTH'(1);
      if (din_vld && !din_rdy) ovr <= 1'b1;
    end
  end

`ifdef FIR_CIRCMEM_SYMFOLD_EN
  logic [MAW-1:0]    raddr_b;
  logic [DWIDTH-1:0] rd_b;
  // wptr-(T-1-k) reduces to wptr+k+1 modulo T.
  assign raddr_b = {rch, wptr + k_full + AWIDTH'(1)};
  assign sum     = {rd_a[DWIDTH-1], rd_a} + {rd_b[DWIDTH-1], rd_b};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_a <= mem[raddr_a];
    rd_b <= mem[raddr_b];
  end
`else
  assign sum = {rd_a[DWIDTH-1], rd_a};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_a <= mem[raddr_a];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      last1     <= 1'b0;
      ch1       <= '0;
      tap1      <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      dout      <= '0;
      dout_ch   <= '0;
      dout_tap  <= '0;
    end else begin
      v1        <= issue;
      last1     <= issue && last_issue;
      dout_vld  <= v1;
      dout_last <= last1;
      if (issue) begin
        ch1  <= rch;
        tap1 <= k_full;
      end
      if (v1) begin
        dout     <= sum;
        dout_ch  <= ch1;
        dout_tap <= tap1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_circmem_mc.sv
// tb_fir_circmem_mc: directed self-checking bench, AWIDTH=3, CWIDTH=1, DWIDTH=16.
`default_nettype none

module tb_fir_circmem_mc;

`ifdef FIR_CIRCMEM_SYMFOLD_EN
  localparam int TAPS = 4;
`else
  localparam int TAPS = 8;
`endif
  localparam int NOUT = 2 * TAPS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_vld = 1'b0;
  logic [31:0] din = '0;
  logic        din_rdy;
  logic [16:0] dout;
  logic        dout_vld;
  logic [0:0]  dout_ch;
  logic [2:0]  dout_tap;
  logic        dout_last;
  logic        ovr;

  int checks = 0;
  int fails  = 0;

  logic [16:0] cap_dout [32];
  logic [0:0]  cap_ch   [32];
  logic [2:0]  cap_tap  [32];
  logic        cap_last [32];
  int          ncap, first_m;
  logic        rdy_in_last, rdy_after;
  logic        rst_vld, rst_rdy, rst_ovr, rst_last;
  logic [16:0] rst_dout;
  logic [16:0] e0 [8];
  logic [16:0] e1 [8];

  fir_circmem_mc #(.DWIDTH(16), .AWIDTH(3), .CWIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_ch(dout_ch), .dout_tap(dout_tap),
    .dout_last(dout_last), .ovr(ovr)
  );

  always #5 clk = ~clk;

  // Offers one frame, then records the output stream sampled on falling edges.
  // m counts falling edges after the accepting rising edge (m=0 is the first).
  task automatic run_frame(input logic [15:0] c0, input logic [15:0] c1,
                           input int pulse_at, input int reset_at);
    int  w;
    bit  done;
    ncap = 0; first_m = -1; rdy_in_last = 1'b1; rdy_after = 1'b0; done = 0;
    w = 0;
    @(negedge clk);
    while (!din_rdy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!din_rdy) begin
      checks++; fails++;
      $display("FAIL accept_timeout: din_rdy=%b required 1", din_rdy);
      return;
    end
    din = {c1, c0};
    din_vld = 1'b1;
    @(posedge clk);
    #1 din_vld = 1'b0;
    din = '0;
    for (int m = 0; m < 100 && !done; m++) begin
      @(negedge clk);
      if (m == reset_at) begin
        rst_n = 1'b0;
        #1;
        rst_vld = dout_vld; rst_dout = dout; rst_rdy = din_rdy;
        rst_ovr = ovr; rst_last = dout_last;
        done = 1;
      end else if (dout_vld) begin
        if (ncap < 32) begin
          cap_dout[ncap] = dout; cap_ch[ncap] = dout_ch;
          cap_tap[ncap] = dout_tap; cap_last[ncap] = dout_last;
        end
        if (first_m < 0) first_m = m;
        rdy_in_last = din_rdy;
        ncap++;
      end else if (ncap > 0) begin
        rdy_after = din_rdy;
        done = 1;
      end
      if (m == pulse_at) begin
        din = {16'hdead, 16'hbeef};
        din_vld = 1'b1;
      end else if (m == pulse_at + 1) begin
        din_vld = 1'b0;
        din = '0;
      end
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL stream_timeout: captured %0d taps required %0d", ncap, NOUT);
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({din_rdy, dout_vld, dout_last, ovr} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: rdy/vld/last/ovr=%b required 0000", {din_rdy, dout_vld, dout_last, ovr});
    end
    checks++;
    if ({dout, dout_ch, dout_tap} !== 21'd0) begin
      fails++;
      $display("FAIL reset_data: dout=%h ch=%h tap=%h required 0", dout, dout_ch, dout_tap);
    end
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!din_rdy && n < 100);
    checks++;
    if (n !== 16) begin
      fails++;
      $display("FAIL clear_length: din_rdy after %0d cycles required 16", n);
    end
  endtask

  task automatic test_first_frame;
    run_frame(16'h0001, 16'h0002, -1, -1);
    checks++;
    if (first_m !== 4) begin
      fails++;
      $display("FAIL first_latency: first dout at %0d required 4", first_m);
    end
    checks++;
    if (ncap !== NOUT) begin
      fails++;
      $display("FAIL first_count: %0d taps required %0d", ncap, NOUT);
    end
    for (int i = 0; i < NOUT && i < ncap; i++) begin
      logic [16:0] ev;
      ev = (i == 0) ? 17'd1 : (i == TAPS) ? 17'd2 : 17'd0;
      checks++;
      if (cap_dout[i] !== ev || cap_ch[i] !== 1'(i / TAPS) || cap_tap[i] !== 3'(i % TAPS)
          || cap_last[i] !== (i == NOUT - 1)) begin
        fails++;
        $display("FAIL first_tap%0d: dout=%h ch=%0d tap=%0d last=%b required %h %0d %0d %b",
                 i, cap_dout[i], cap_ch[i], cap_tap[i], cap_last[i], ev, i / TAPS, i % TAPS, i == NOUT - 1);
      end
    end
    checks++;
    if (rdy_in_last !== 1'b0 || rdy_after !== 1'b1) begin
      fails++;
      $display("FAIL rdy_after_last: during=%b after=%b required 0 1", rdy_in_last, rdy_after);
    end
  endtask

  task automatic test_wrap;
    for (int v = 2; v <= 10; v++) begin
      run_frame(16'(v), 16'h0000, -1, -1);
      checks++;
      if (ncap !== NOUT) begin
        fails++;
        $display("FAIL wrap_count%0d: %0d taps required %0d", v, ncap, NOUT);
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_dout[k] !== 17'(10 - k) || cap_dout[8 + k] !== 17'd0) begin
        fails++;
        $display("FAIL wrap_tap%0d: ch0=%h ch1=%h required %h 0", k, cap_dout[k], cap_dout[8 + k], 17'(10 - k));
      end
    end
  endtask

  task automatic test_sign;
    run_frame(16'h8000, 16'h7fff, -1, -1);
    checks++;
    if (cap_dout[0] !== 17'h18000 || cap_dout[1] !== 17'd10) begin
      fails++;
      $display("FAIL sign_ch0: tap0=%h tap1=%h required 18000 0000a", cap_dout[0], cap_dout[1]);
    end
    checks++;
    if (cap_dout[8] !== 17'h07fff || cap_dout[9] !== 17'd0) begin
      fails++;
      $display("FAIL sign_ch1: tap0=%h tap1=%h required 07fff 0", cap_dout[8], cap_dout[9]);
    end
  endtask

  task automatic test_overrun;
    e0 = '{17'd5, 17'h18000, 17'd10, 17'd9, 17'd8, 17'd7, 17'd6, 17'd5};
    e1 = '{17'd0, 17'h07fff, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0};
    checks++;
    if (ovr !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clean: ovr=%b required 0", ovr);
    end
    run_frame(16'h0005, 16'h0000, 8, -1);
    checks++;
    if (ovr !== 1'b1 || ncap !== NOUT) begin
      fails++;
      $display("FAIL ovr_set: ovr=%b taps=%0d required 1 %0d", ovr, ncap, NOUT);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_dout[k] !== e0[k] || cap_dout[8 + k] !== e1[k]) begin
        fails++;
        $display("FAIL ovr_tap%0d: ch0=%h ch1=%h required %h %h", k, cap_dout[k], cap_dout[8 + k], e0[k], e1[k]);
      end
    end
    run_frame(16'h0006, 16'h0000, -1, -1);
    checks++;
    if (ncap !== NOUT || first_m !== 4 || ovr !== 1'b1) begin
      fails++;
      $display("FAIL ovr_next_frame: taps=%0d first=%0d ovr=%b required %0d 4 1", ncap, first_m, ovr, NOUT);
    end
    checks++;
    if (cap_dout[0] !== 17'd6 || cap_dout[1] !== 17'd5 || cap_dout[2] !== 17'h18000) begin
      fails++;
      $display("FAIL ovr_next_data: %h %h %h required 00006 00005 18000", cap_dout[0], cap_dout[1], cap_dout[2]);
    end
  endtask

  task automatic test_reset_mid_read;
    int n;
    run_frame(16'h0007, 16'h0000, -1, 6);
    checks++;
    if ({rst_vld, rst_last, rst_rdy, rst_ovr} !== 4'b0000 || rst_dout !== 17'd0) begin
      fails++;
      $display("FAIL midreset_outputs: vld/last/rdy/ovr=%b dout=%h required 0000 0",
               {rst_vld, rst_last, rst_rdy, rst_ovr}, rst_dout);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!din_rdy && n < 100);
    checks++;
    if (n !== 16) begin
      fails++;
      $display("FAIL midreset_clear: din_rdy after %0d cycles required 16", n);
    end
    run_frame(16'h0003, 16'h0004, -1, -1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_dout[k] !== ((k == 0) ? 17'd3 : 17'd0) || cap_dout[8 + k] !== ((k == 0) ? 17'd4 : 17'd0)) begin
        fails++;
        $display("FAIL midreset_tap%0d: ch0=%h ch1=%h required %0d %0d", k, cap_dout[k], cap_dout[8 + k],
                 (k == 0) ? 3 : 0, (k == 0) ? 4 : 0);
      end
    end
  endtask

  task automatic test_fold;
    for (int v = 1; v <= 8; v++) run_frame(16'(v), 16'h0000, -1, -1);
    checks++;
    if (ncap !== 8 || first_m !== 4) begin
      fails++;
      $display("FAIL fold_count: taps=%0d first=%0d required 8 4", ncap, first_m);
    end
    for (int i = 0; i < 8 && i < ncap; i++) begin
      checks++;
      if (cap_dout[i] !== ((i < 4) ? 17'd9 : 17'd0) || cap_tap[i] !== 3'(i % 4)
          || cap_ch[i] !== 1'(i / 4) || cap_last[i] !== (i == 7)) begin
        fails++;
        $display("FAIL fold_tap%0d: dout=%h tap=%0d ch=%0d last=%b required %0d %0d %0d %b", i,
                 cap_dout[i], cap_tap[i], cap_ch[i], cap_last[i], (i < 4) ? 9 : 0, i % 4, i / 4, i == 7);
      end
    end
  endtask

  initial begin
    test_reset;
`ifdef FIR_CIRCMEM_SYMFOLD_EN
    test_fold;
`else
    test_first_frame;
    test_wrap;
    test_sign;
    test_overrun;
    test_reset_mid_read;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
